// File: rtl/booth_accumulator.sv
// ---------------------------------------------------------------------------
// booth_accumulator
//
// Sequential radix-4 Booth multiplier: control and accumulation stage.
// Accepts a signed operand pair over a valid/ready handshake, then walks
// the multiplier one Booth group per cycle. For every group it presents
// the group bits, the group index and the latched multiplicand to an
// external BoothEncoder, and adds the partial product the encoder returns
// (already shifted by 2*i) into a 2*N_BITS accumulator. When the last
// group has been summed the product is offered downstream on a
// valid/ready handshake.
//
// Parameters
//   N_BITS            operand width; even, 4..64
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   in_valid          operand pair valid
//   in_ready          block can accept operands (IDLE only)
//   multiplicand      signed operand A
//   multiplier        signed operand B (Booth-recoded internally)
//   enc_multiplicand  latched A, to encoder
//   enc_group_index   current group index i, to encoder
//   enc_booth_group   {B[2i+1], B[2i], B[2i-1]} with B[-1] = 0, to encoder
//   enc_pp            partial product from encoder for the current group
//   out_valid         product valid (DONE only)
//   out_ready         downstream accepts product
//   product           signed A*B, 2*N_BITS wide
//
// Configuration
//   BOOTH_EARLY_EXIT_EN  when defined, finish as soon as every remaining
//                        multiplier group is 000/111 (they contribute
//                        zero), giving a latency of 1..N_BITS/2 cycles.
//                        When undefined, latency is always N_BITS/2.
// ---------------------------------------------------------------------------
module booth_accumulator #(
  parameter int N_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_BITS-1:0]     multiplicand,
  input  logic [N_BITS-1:0]     multiplier,
  output logic [N_BITS-1:0]     enc_multiplicand,
  output logic [4:0]            enc_group_index,
  output logic [2:0]            enc_booth_group,
  input  logic [2*N_BITS:0]     enc_pp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*N_BITS-1:0]   product
);

  localparam int          PROD_W   = 2 * N_BITS;
  localparam logic [4:0]  LAST_IDX = 5'(N_BITS / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   a_q, a_d;
  logic [N_BITS-1:0]   b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [4:0]          idx_q, idx_d;

  logic [5:0]          group_shift;
  logic [N_BITS:0]     b_ext;
  logic [N_BITS:0]     b_shifted;
  logic [2:0]          group_bits;
  logic                last_group;

  // The top bit of enc_pp only exists for the encoder's own sign handling;
  // the accumulator works modulo 2^(2*N_BITS) so it is deliberately dropped.
  logic                unused_pp_msb;
  assign unused_pp_msb = enc_pp[PROD_W];

  // Select the current Booth group. Appending a zero below B supplies the
  // implicit B[-1] = 0, so group i is simply bits [2i+2:2i] of the extended
  // value.
  always_comb begin
    group_shift = {idx_q, 1'b0};
    b_ext       = {b_q, 1'b0};
    b_shifted   = b_ext >> group_shift;
    group_bits  = b_shifted[2:0];
  end

`ifdef BOOTH_EARLY_EXIT_EN
  logic [5:0]          upper_shift;
  logic [N_BITS-1:0]   upper_bits;
  logic                upper_uniform;

  // After group i, the remaining groups are all 000/111 exactly when
  // B[N_BITS-1:2i+1] is all zeros or all ones. An arithmetic shift by 2i+1
  // fills the vacated bits with the sign, so the shifted value is then
  // entirely zeros or entirely ones.
  always_comb begin
    upper_shift   = {idx_q, 1'b1};
    upper_bits    = $signed(b_q) >>> upper_shift;
    upper_uniform = (upper_bits == '0) || (&upper_bits);
    last_group    = (idx_q == LAST_IDX) || upper_uniform;
  end
`else
  // Fixed latency: the walk ends only after the final group.
  always_comb begin
    last_group = (idx_q == LAST_IDX);
  end
`endif

  // State register. Reset aborts any operation in flight and discards the
  // pending product, so no stale out_valid can appear afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. Inputs are only looked at in IDLE, so operand or
  // in_valid activity during ACCUM/DONE has no effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = ACCUM;
      ACCUM:   if (last_group) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath next values. The accumulator is not touched on the accept
  // edge; instead the first ACCUM edge (i = 0) loads the partial product
  // over a zero base. The sum starts from zero exactly as if it had been
  // cleared at accept, while the visible product still only changes on
  // ACCUM edges and on reset.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = multiplicand;
          b_d   = multiplier;
          idx_d = '0;
        end
      end
      ACCUM: begin
        acc_d = ((idx_q == '0) ? '0 : acc_q) + enc_pp[PROD_W-1:0];
        idx_d = idx_q + 5'd1;
      end
      default: begin
      end
    endcase
  end

  // Outputs. Outside ACCUM the encoder sees group 000 at index 0, which
  // forces a zero partial product; the multiplicand simply keeps its last
  // latched value so its bus does not toggle needlessly.
  always_comb begin
    in_ready         = (state_q == IDLE);
    out_valid        = (state_q == DONE);
    product          = acc_q;
    enc_multiplicand = a_q;
    enc_group_index  = '0;
    enc_booth_group  = 3'b000;
    if (state_q == ACCUM) begin
      enc_group_index = idx_q;
      enc_booth_group = group_bits;
    end
  end

endmodule

// File: tb/tb_booth_accumulator.sv
// ---------------------------------------------------------------------------
// tb_booth_accumulator
//
// Bench for booth_accumulator at N_BITS = 32. A behavioural BoothEncoder
// model closes the partial-product loop. Stimulus pushes the hand-computed
// product and latency of each accepted operand pair into a scoreboard
// queue; an independent monitor pops an entry whenever out_valid appears
// and compares it, optionally stalling out_ready to check output hold.
// Build with +define+BOOTH_EARLY_EXIT_EN to expect early-exit latencies.
// ---------------------------------------------------------------------------
module tb_booth_accumulator;

  localparam int FULL_LAT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [31:0] enc_multiplicand;
  logic [4:0]  enc_group_index;
  logic [2:0]  enc_booth_group;
  logic [64:0] enc_pp;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] product;

  int cycle = 0;
  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [63:0] prod;
    int          lat;
    int          stall;
    int          accept_cycle;
    string       name;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          lat_early;
    string       name;
  } vec_t;

  vec_t vecs[7];

  booth_accumulator #(.N_BITS(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .multiplicand     (multiplicand),
    .multiplier       (multiplier),
    .enc_multiplicand (enc_multiplicand),
    .enc_group_index  (enc_group_index),
    .enc_booth_group  (enc_booth_group),
    .enc_pp           (enc_pp),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .product          (product)
  );

  // Free-running clock and a cycle counter used to measure latencies.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural BoothEncoder: digit in {-2..2} times sign-extended A,
  // shifted left by 2*i, 65 bits wide.
  function automatic logic [64:0] encoderModel(input logic [2:0] g,
                                                input logic [31:0] a,
                                                input logic [4:0] i);
    logic signed [64:0] a_ext;
    logic signed [64:0] digit;
    logic signed [64:0] pp;
    a_ext = {{33{a[31]}}, a};
    case (g)
      3'b001, 3'b010: digit = 65'sd1;
      3'b011:         digit = 65'sd2;
      3'b100:         digit = -65'sd2;
      3'b101, 3'b110: digit = -65'sd1;
      default:        digit = 65'sd0;
    endcase
    pp = (a_ext * digit) <<< (2 * int'(i));
    return pp;
  endfunction

  always_comb enc_pp = encoderModel(enc_booth_group, enc_multiplicand, enc_group_index);

  // Expected latency for a given early-exit latency in the current build.
  function automatic int expLat(input int lat_early);
`ifdef BOOTH_EARLY_EXIT_EN
    return lat_early;
`else
    return (lat_early > 0) ? FULL_LAT : FULL_LAT;
`endif
  endfunction

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer an operand pair, wait (bounded) for acceptance, and optionally
  // push the expected response into the scoreboard.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] prod, input int lat,
                               input int stall, input string name,
                               input bit push, output int accept_cycle);
    int waited;
    exp_t e;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    waited       = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s_accept_timeout: in_ready stayed 0, expected 1", name);
      in_valid     = 1'b0;
      accept_cycle = cycle;
      return;
    end
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    accept_cycle = cycle;
    if (push) begin
      e.prod         = prod;
      e.lat          = lat;
      e.stall        = stall;
      e.accept_cycle = accept_cycle;
      e.name         = name;
      sb.push_back(e);
    end
  endtask

  // Monitor: pops the scoreboard on the first out_valid cycle, checks
  // latency and product, holds out_ready low for the requested stall while
  // checking the output stays put, then checks the release handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !rst) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_out_valid: got out_valid=1 product=0x%0h, expected no output", product);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_latency"}, 64'(cycle - e.accept_cycle), 64'(e.lat));
          checkOutput({e.name, "_product"}, product, e.prod);
          if (e.stall > 0) begin
            out_ready = 1'b0;
            for (int s = 0; s < e.stall; s++) begin
              @(negedge clk);
              checkOutput({e.name, "_hold_valid"}, 64'(out_valid), 64'd1);
              checkOutput({e.name, "_hold_product"}, product, e.prod);
              checkOutput({e.name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
          end
          @(negedge clk);
          checkOutput({e.name, "_release_valid"}, 64'(out_valid), 64'd0);
          checkOutput({e.name, "_release_in_ready"}, 64'(in_ready), 64'd1);
        end
      end
    end
  end

  // Watchdog so the run always ends even if the design stalls.
  initial begin
    #200000;
    n_mismatched++;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Main directed sequence.
  initial begin
    int acc1;
    int acc2;
    int waited;
    logic [2:0] exp_grp;

    vecs[0] = '{32'd7,        32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 2,  "a7_bm3"};
    vecs[1] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, 16, "min_sq"};
    vecs[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, 16, "max_sq"};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 1,  "m1_sq"};
    vecs[4] = '{32'd9,        32'd5,        64'd45,               2,  "a9_b5"};
    vecs[5] = '{32'd9,        32'd0,        64'd0,                1,  "b_zero"};
    vecs[6] = '{32'hFFFFFF9C, 32'h00012345, 64'hFFFFFFFFFF8E390C, 9,  "am100_b12345"};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready",  64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_product",   product, 64'd0);
    checkOutput("reset_enc_mcand", 64'(enc_multiplicand), 64'd0);
    checkOutput("reset_enc_index", 64'(enc_group_index), 64'd0);
    checkOutput("reset_enc_group", 64'(enc_booth_group), 64'd0);
    rst = 1'b0;

    // Back-to-back directed products.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].prod, expLat(vecs[v].lat_early),
                    0, vecs[v].name, 1'b1, acc1);
    end

    // Encoder-side trace for B = 0xD: groups 010, 110, 001, then 000.
    applyStimulus(32'h1234, 32'h0000000D, 64'hECA4, expLat(3), 0, "enc_trace", 1'b1, acc1);
    for (int k = 0; k < expLat(3); k++) begin
      @(negedge clk);
      case (k)
        0:       exp_grp = 3'b010;
        1:       exp_grp = 3'b110;
        2:       exp_grp = 3'b001;
        default: exp_grp = 3'b000;
      endcase
      checkOutput($sformatf("enc_trace_index_%0d", k), 64'(enc_group_index), 64'(k));
      checkOutput($sformatf("enc_trace_group_%0d", k), 64'(enc_booth_group), 64'(exp_grp));
      checkOutput($sformatf("enc_trace_mcand_%0d", k), 64'(enc_multiplicand), 64'h1234);
    end

    // Output stall of 5 cycles with a concurrent in_valid that must be
    // ignored, then the next accept one cycle after the handshake.
    applyStimulus(32'd12, 32'd10, 64'd120, expLat(3), 5, "stall_a12_b10", 1'b1, acc1);
    repeat (expLat(3) + 1) @(negedge clk);
    multiplicand = 32'hDEAD;
    multiplier   = 32'hBEEF;
    in_valid     = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(32'hFFFFFFFB, 32'd6, 64'hFFFFFFFFFFFFFFE2, expLat(2), 0,
                  "after_stall", 1'b1, acc2);
    checkOutput("accept_spacing", 64'(acc2 - acc1), 64'(expLat(3) + 7));

    // Reset in the middle of accumulation at group index 7.
    applyStimulus(32'h1234, 32'h40000001, 64'd0, 0, 0, "aborted", 1'b0, acc1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (enc_group_index != 5'd7 && waited < 40);
    checkOutput("abort_reached_index7", 64'(enc_group_index), 64'd7);
    checkOutput("abort_partial_product", product, 64'h1234);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_in_ready",  64'(in_ready), 64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_product",   product, 64'd0);
    checkOutput("abort_enc_index", 64'(enc_group_index), 64'd0);
    applyStimulus(32'd3, 32'd5, 64'd15, expLat(2), 0, "post_abort_a3_b5", 1'b1, acc1);

    // Drain the scoreboard (bounded).
    waited = 0;
    while (sb.size() > 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
